// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: the sequencer state encoding consumed by control and
// datapath, plus the default halt address.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } cpu_state_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the bus-based MIPS CPU:
// stalls on waitrequest, latches IR/MDR, pulses pc_wren and counts retirements.
module cpu_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] pc_next,
  output logic [2:0]  state,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic        pc_wren,
  output logic        active,
  output logic [31:0] retired
);

  cpu_state_t state_q;
  cpu_state_t state_d;
  logic       ir_load;
  logic       mdr_load;
  logic       retire;

  // Next-state and register load enables. Handshake: the bus completes a
  // transfer on any cycle where a request is pending and waitrequest is low.
  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    retire   = 1'b0;
    case (state_q)
      FETCH: begin
        if (!waitrequest) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = MEM;
      MEM: begin
        // waitrequest only matters when an access is actually requested
        if (!((mem_read || mem_write) && waitrequest)) begin
          mdr_load = mem_read;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        retire  = 1'b1;
        state_d = (pc_next == HALT_ADDR) ? HALTED : FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      instr   <= 32'h0;
      mdr     <= 32'h0;
      retired <= 32'h0;
      active  <= 1'b1;
    end else begin
      state_q <= state_d;
      active  <= (state_d != HALTED);
      if (ir_load) instr <= readdata;
      if (mdr_load) mdr <= readdata;
      if (retire) retired <= retired + 32'd1;
    end
  end

  assign state   = state_q;
  assign pc_wren = (state_q == EXEC);

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Randomized bench for cpu_state_sequencer: an instruction-level reference
// model predicts the phase sequence, IR/MDR contents and retirement count.
module tb_cpu_state_sequencer;

  logic        clk;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] pc_next;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [31:0] mdr;
  logic        pc_wren;
  logic        active;
  logic [31:0] retired;

  cpu_state_sequencer dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
    .mem_read(mem_read), .mem_write(mem_write), .pc_next(pc_next),
    .state(state), .instr(instr), .mdr(mdr), .pc_wren(pc_wren),
    .active(active), .retired(retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // reference model: architectural contents, not an FSM
  logic [31:0] m_instr;
  logic [31:0] m_mdr;
  logic [31:0] m_ret;
  logic        m_active;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic [2:0] exp_state);
    check("state", {29'd0, state}, {29'd0, exp_state});
    check("pc_wren", {31'd0, pc_wren}, {31'd0, exp_state == 3'd3});
    check("instr", instr, m_instr);
    check("mdr", mdr, m_mdr);
    check("retired", retired, m_ret);
    check("active", {31'd0, active}, {31'd0, m_active});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_instr  = 32'h0;
    m_mdr    = 32'h0;
    m_ret    = 32'h0;
    m_active = 1'b1;
  endtask

  // background noise on inputs the current phase ignores
  task automatic noise();
    readdata  = $urandom;
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    pc_next   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endtask

  // driver: one whole instruction. op: 0 none, 1 load, 2 store.
  // fw/mw: stall cycles in FETCH/MEM (for op 0, mw!=0 raises waitrequest anyway).
  task automatic run_instr(input int fw, input int op, input int mw,
                           input logic [31:0] ir, input logic [31:0] rd,
                           input logic [31:0] pcn);
    int mem_cycles;
    for (int i = 0; i <= fw; i++) begin
      check_all(3'd0);
      noise();
      waitrequest = (i < fw);
      if (i == fw) readdata = ir;
      tick();
    end
    m_instr = ir;
    check_all(3'd1);
    noise();
    waitrequest = 1'($urandom_range(0, 1));
    tick();
    mem_cycles = (op != 0) ? mw + 1 : 1;
    for (int i = 0; i < mem_cycles; i++) begin
      check_all(3'd2);
      readdata    = (i == mem_cycles - 1) ? rd : $urandom;
      mem_read    = (op == 1);
      mem_write   = (op == 2);
      pc_next     = $urandom;
      waitrequest = (op != 0) ? (i < mw) : (mw != 0);
      tick();
    end
    if (op == 1) m_mdr = rd;
    check_all(3'd3);
    noise();
    waitrequest = 1'($urandom_range(0, 1));
    pc_next = pcn;
    tick();
    m_ret = m_ret + 32'd1;
    if (pcn == 32'h0) m_active = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    waitrequest = 1'b0;
    readdata = 32'h0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    pc_next = 32'h4;
    model_reset();
    tick();
    tick();
    check_all(3'd0);
    reset = 1'b0;

    // plain instruction, no access, then FETCH stall, load stall, no-access wait
    run_instr(0, 0, 0, 32'h2408_0005, 32'h1111_1111, 32'h4);
    check("first_retire", retired, 32'd1);
    run_instr(3, 0, 0, 32'h3c01_1234, 32'h0, 32'h8);
    run_instr(0, 1, 2, 32'h8c22_0000, 32'hDEAD_BEEF, 32'hC);
    check("load_mdr", mdr, 32'hDEAD_BEEF);
    run_instr(0, 0, 1, 32'h0000_0020, 32'h5555_5555, 32'h10);
    run_instr(1, 2, 3, 32'hac22_0004, 32'h7777_7777, 32'h14);

    // randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      logic [31:0] pcn;
      pcn = $urandom;
      if (pcn == 32'h0) pcn = 32'h4;
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom, $urandom, pcn);
    end

    // asynchronous reset mid MEM stall: no partial retirement
    check_all(3'd0);
    waitrequest = 1'b0;
    readdata = 32'hABCD_0001;
    tick();
    m_instr = 32'hABCD_0001;
    check_all(3'd1);
    tick();
    mem_read = 1'b1;
    mem_write = 1'b0;
    waitrequest = 1'b1;
    tick();
    check_all(3'd2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(3'd0);
    tick();
    check_all(3'd0);
    reset = 1'b0;
    waitrequest = 1'b0;

    run_instr(2, 1, 1, 32'h8c01_0008, 32'hCAFE_F00D, 32'h4);
    run_instr(0, 0, 0, 32'h0800_0000, 32'h0, 32'h0);

    // halted: frozen regardless of inputs
    for (int i = 0; i < 20; i++) begin
      check_all(3'd4);
      noise();
      waitrequest = 1'($urandom_range(0, 1));
      tick();
    end

    // reset leaves HALTED
    reset = 1'b1;
    #1;
    model_reset();
    check_all(3'd0);
    tick();
    reset = 1'b0;
    run_instr(0, 0, 0, 32'h2408_0005, 32'h0, 32'h4);
    check_all(3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
